// File: rtl/bch_chien_parallel_pkg.sv
// Shared GF(2^M) helpers for the parallel Chien search: primitive polynomial
// table, constant-foldable multiply, alpha-power lookup, clog2 and FSM states.
package bch_chien_parallel_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} chien_state_t;

  function automatic int unsigned prim_poly(input int m);
    case (m)
      3:       return 32'h0000_000B;
      4:       return 32'h0000_0013;
      5:       return 32'h0000_0025;
      6:       return 32'h0000_0043;
      7:       return 32'h0000_0089;
      8:       return 32'h0000_011D;
      9:       return 32'h0000_0211;
      10:      return 32'h0000_0409;
      11:      return 32'h0000_0805;
      12:      return 32'h0000_1053;
      13:      return 32'h0000_201B;
      14:      return 32'h0000_4443;
      15:      return 32'h0000_8003;
      16:      return 32'h0001_100B;
      default: return 32'h0000_0013;
    endcase
  endfunction

  // With one operand constant this collapses to a pure XOR network.
  function automatic int unsigned gf_mul(input int m, input int unsigned a, input int unsigned b);
    int unsigned acc;
    int unsigned x;
    acc = 0;
    x = a;
    for (int k = 0; k < m; k++) begin
      if (((b >> k) & 32'd1) != 0) acc ^= x;
      x = x << 1;
      if (((x >> m) & 32'd1) != 0) x ^= prim_poly(m);
    end
    return acc;
  endfunction

  function automatic int unsigned lpow(input int m, input int e);
    int unsigned r;
    int n;
    n = (1 << m) - 1;
    r = 1;
    for (int k = 0; k < e % n; k++) r = gf_mul(m, r, 2);
    return r;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bch_chien_term.sv
// One sigma coefficient of the Chien search: holds z_I, offers P lane taps
// z_I*alpha^(I*p) and advances by alpha^(I*P) per beat.
module bch_chien_term
  import bch_chien_parallel_pkg::*;
#(
  parameter int M      = 4,
  parameter int I      = 0,
  parameter int P      = 4,
  parameter int OFFSET = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [M-1:0]   coef,
  output logic [P*M-1:0] taps
);
  localparam int unsigned LOAD_C = lpow(M, I * OFFSET);
  localparam int unsigned STEP_C = lpow(M, I * P);

  logic [M-1:0] z_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     z_reg <= '0;
    else if (load) z_reg <= M'(gf_mul(M, 32'(coef), LOAD_C));
    else if (step) z_reg <= M'(gf_mul(M, 32'(z_reg), STEP_C));
  end

  for (genvar gi = 0; gi < P; gi++) begin : g_tap
    localparam int unsigned TAP_C = lpow(M, I * gi);
    assign taps[gi*M +: M] = M'(gf_mul(M, 32'(z_reg), TAP_C));
  end

endmodule

// File: rtl/bch_chien_parallel.sv
// P-lane parallel Chien search with valid/ready output beats.
// Define BCH_CHIEN_COUNT_EN to flag words whose root count differs from deg(sigma).
module bch_chien_parallel
  import bch_chien_parallel_pkg::*;
#(
  parameter int M      = 4,
  parameter int K      = 11,
  parameter int T      = 1,
  parameter int P      = 4,
  parameter int OFFSET = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [M*(T+1)-1:0] sigma,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P-1:0]       err,
  output logic               first,
  output logic               last,
  output logic               fail
);
  localparam int B  = (K + P - 1) / P;
  localparam int BW = clog2(B + 1);

  chien_state_t   state_reg;
  logic [BW-1:0]  beat_reg;
  logic           in_ready_reg, out_valid_reg, first_reg, last_reg, fail_reg;
  logic [P-1:0]   err_reg;
  logic [P*M-1:0] taps [T+1];
  logic [P-1:0]   err_next;
  logic           last_next, fail_next;
  logic           load, emit, xfer;

  assign xfer      = out_valid_reg && out_ready;
  assign load      = (state_reg == ST_IDLE) && start && in_ready_reg;
  // z always holds the beat that gets registered next, so emitting also steps it.
  assign emit      = (state_reg == ST_LOAD) || ((state_reg == ST_RUN) && xfer && !last_reg);
  assign last_next = (beat_reg == BW'(B - 1));

  for (genvar gi = 0; gi <= T; gi++) begin : g_term
    bch_chien_term #(.M(M), .I(gi), .P(P), .OFFSET(OFFSET)) u_term (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .step  (emit),
      .coef  (sigma[gi*M +: M]),
      .taps  (taps[gi])
    );
  end

  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    logic [M-1:0] lane_sum;
    always_comb begin
      lane_sum = '0;
      for (int i = 0; i <= T; i++) lane_sum ^= taps[i][gi*M +: M];
    end
    assign err_next[gi] = (lane_sum == '0) && ((int'(beat_reg) * P + gi) < K);
  end

`ifdef BCH_CHIEN_COUNT_EN
  localparam int CW   = (T > 0) ? clog2(T + 1) : 1;
  localparam int CMAX = (1 << CW) - 1;

  logic [CW-1:0] count_reg, deg_reg, count_next, deg_in;

  always_comb begin
    int sum;
    sum = (state_reg == ST_LOAD) ? 0 : int'(count_reg);
    sum += $countones(err_next);
    count_next = (sum > CMAX) ? CW'(CMAX) : CW'(sum);
    deg_in = '0;
    for (int i = 1; i <= T; i++) if (sigma[i*M +: M] != '0) deg_in = CW'(i);
  end

  assign fail_next = last_next && (count_next != deg_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      deg_reg   <= '0;
    end else begin
      if (load) deg_reg <= deg_in;
      if (emit) count_reg <= count_next;
    end
  end
`else
  assign fail_next = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      beat_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      err_reg       <= '0;
      first_reg     <= 1'b0;
      last_reg      <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: if (load) begin
          state_reg    <= ST_LOAD;
          in_ready_reg <= 1'b0;
          beat_reg     <= '0;
        end
        ST_LOAD: begin
          state_reg     <= ST_RUN;
          out_valid_reg <= 1'b1;
          first_reg     <= 1'b1;
        end
        ST_RUN: if (xfer) begin
          first_reg <= 1'b0;
          if (last_reg) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            last_reg      <= 1'b0;
            err_reg       <= '0;
            fail_reg      <= 1'b0;
            beat_reg      <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (emit) begin
        err_reg  <= err_next;
        last_reg <= last_next;
        fail_reg <= fail_next;
        beat_reg <= beat_reg + BW'(1);
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign err       = err_reg;
  assign first     = first_reg;
  assign last      = last_reg;
  assign fail      = fail_reg;

endmodule

// File: tb/tb_bch_chien_parallel.sv
// Directed bench for bch_chien_parallel over GF(16), x^4+x+1, K=11, OFFSET=1.
module tb_bch_chien_parallel;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

`ifdef BCH_CHIEN_COUNT_EN
  localparam logic FAIL_ON = 1'b1;
`else
  localparam logic FAIL_ON = 1'b0;
`endif

  // dut_a: T=1 P=4
  logic start_a = 1'b0, out_ready_a = 1'b0;
  logic [7:0] sigma_a = '0;
  logic in_ready_a, out_valid_a, first_a, last_a, fail_a;
  logic [3:0] err_a;
  // dut_b/c/d: T=2 with P=4, 1, 11 sharing one sigma
  logic [11:0] sigma2 = '0;
  logic start_b = 1'b0, out_ready_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
  logic in_ready_b, out_valid_b, first_b, last_b, fail_b;
  logic [3:0] err_b;
  logic in_ready_c, out_valid_c, first_c, last_c, fail_c;
  logic [0:0] err_c;
  logic in_ready_d, out_valid_d, first_d, last_d, fail_d;
  logic [10:0] err_d;

  bch_chien_parallel #(.M(4), .K(11), .T(1), .P(4), .OFFSET(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .sigma(sigma_a), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .err(err_a), .first(first_a),
    .last(last_a), .fail(fail_a));
  bch_chien_parallel #(.M(4), .K(11), .T(2), .P(4), .OFFSET(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .sigma(sigma2), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .err(err_b), .first(first_b),
    .last(last_b), .fail(fail_b));
  bch_chien_parallel #(.M(4), .K(11), .T(2), .P(1), .OFFSET(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .sigma(sigma2), .in_ready(in_ready_c),
    .out_valid(out_valid_c), .out_ready(1'b1), .err(err_c), .first(first_c),
    .last(last_c), .fail(fail_c));
  bch_chien_parallel #(.M(4), .K(11), .T(2), .P(11), .OFFSET(1)) dut_d (
    .clk(clk), .reset(reset), .start(start_d), .sigma(sigma2), .in_ready(in_ready_d),
    .out_valid(out_valid_d), .out_ready(1'b1), .err(err_d), .first(first_d),
    .last(last_d), .fail(fail_d));

  int xfer_a = 0;
  always @(posedge clk) if (out_valid_a && out_ready_a) xfer_a <= xfer_a + 1;

  task automatic test_reset();
    logic [8:0] got9;
    logic [15:0] got16;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got9 = {in_ready_a, out_valid_a, first_a, last_a, fail_a, err_a};
    total++;
    if (got9 !== 9'h100) begin bad++; $display("FAIL reset_a got=%b want=%b", got9, 9'h100); end
    got9 = {in_ready_b, out_valid_b, first_b, last_b, fail_b, err_b};
    total++;
    if (got9 !== 9'h100) begin bad++; $display("FAIL reset_b got=%b want=%b", got9, 9'h100); end
    got16 = {in_ready_d, out_valid_d, first_d, last_d, fail_d, err_d};
    total++;
    if (got16 !== 16'h8000) begin bad++; $display("FAIL reset_d got=%b want=%b", got16, 16'h8000); end
    reset = 1'b0;
    $display("reset released");
  endtask

  // sigma(x) = 1 + alpha^10 x: single root at alpha^5, i.e. location j=4.
  task automatic test_single_root(input int stall_cycles, input string tag);
    logic [7:0] got, want;
    @(negedge clk);
    sigma_a = 8'h71; start_a = 1'b1; out_ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    total++;
    if ({in_ready_a, out_valid_a} !== 2'b00) begin
      bad++; $display("FAIL %s_latency got=%b want=00", tag, {in_ready_a, out_valid_a});
    end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      want = {1'b1, (b == 0), (b == 2), ((b == 1) ? 4'b0001 : 4'b0000), 1'b0};
      if (b == 1) begin
        for (int s = 0; s < stall_cycles; s++) begin
          got = {out_valid_a, first_a, last_a, err_a, fail_a};
          total++;
          if (got !== want) begin bad++; $display("FAIL %s_hold%0d got=%b want=%b", tag, s, got, want); end
          out_ready_a = 1'b0;
          @(negedge clk);
        end
        out_ready_a = 1'b1;
      end
      got = {out_valid_a, first_a, last_a, err_a, fail_a};
      $display("%s beat %0d err=%b first=%b last=%b", tag, b, err_a, first_a, last_a);
      total++;
      if (got !== want) begin bad++; $display("FAIL %s_beat%0d got=%b want=%b", tag, b, got, want); end
    end
    @(negedge clk);
    total++;
    if ({in_ready_a, out_valid_a} !== 2'b10) begin
      bad++; $display("FAIL %s_idle got=%b want=10", tag, {in_ready_a, out_valid_a});
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = xfer_a;
    test_single_root(5, "stall");
    total++;
    if (xfer_a - base !== 3) begin bad++; $display("FAIL stall_xfers got=%0d want=3", xfer_a - base); end
  endtask

  // w0: roots alpha^1, alpha^11 (j=0,10); w1: roots alpha^1, alpha^14 (j=0, j=13 beyond K).
  task automatic test_two_roots();
    logic [11:0] sig [2];
    logic [3:0] e2 [2];
    logic fl [2];
    logic [7:0] got, want;
    sig[0] = 12'h1CF; e2[0] = 4'b0100; fl[0] = 1'b0;
    sig[1] = 12'h1B1; e2[1] = 4'b0000; fl[1] = FAIL_ON;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      sigma2 = sig[w]; start_b = 1'b1; out_ready_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int b = 0; b < 3; b++) begin
        @(negedge clk);
        want = {1'b1, (b == 0), (b == 2),
                ((b == 0) ? 4'b0001 : ((b == 2) ? e2[w] : 4'b0000)),
                ((b == 2) ? fl[w] : 1'b0)};
        got = {out_valid_b, first_b, last_b, err_b, fail_b};
        $display("roots%0d beat %0d err=%b last=%b fail=%b", w, b, err_b, last_b, fail_b);
        total++;
        if (got !== want) begin bad++; $display("FAIL roots%0d_beat%0d got=%b want=%b", w, b, got, want); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_errors();
    logic [7:0] got, want;
    @(negedge clk);
    sigma2 = 12'h001; start_b = 1'b1; out_ready_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      start_b = (b == 1);
      want = {1'b1, (b == 0), (b == 2), 4'b0000, 1'b0};
      got = {out_valid_b, first_b, last_b, err_b, fail_b};
      $display("clean beat %0d err=%b last=%b", b, err_b, last_b);
      total++;
      if (got !== want) begin bad++; $display("FAIL clean_beat%0d got=%b want=%b", b, got, want); end
    end
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({in_ready_b, out_valid_b} !== 2'b10) begin
        bad++; $display("FAIL clean_idle%0d got=%b want=10", k, {in_ready_b, out_valid_b});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    @(negedge clk);
    sigma_a = 8'h71; start_a = 1'b1; out_ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (err_a !== 4'b0001) begin bad++; $display("FAIL abort_pre got=%b want=0001", err_a); end
    reset = 1'b1;
    #1;
    got = {out_valid_a, in_ready_a, first_a, last_a, err_a};
    $display("reset mid-word out_valid=%b in_ready=%b", out_valid_a, in_ready_a);
    total++;
    if (got !== 8'b0100_0000) begin bad++; $display("FAIL abort got=%b want=%b", got, 8'b0100_0000); end
    @(negedge clk);
    reset = 1'b0;
    test_single_root(0, "rerun");
  endtask

  task automatic test_p1();
    logic [10:0] mask;
    logic [3:0] got, want;
    mask = '0;
    @(negedge clk);
    sigma2 = 12'h1CF; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int b = 0; b < 11; b++) begin
      @(negedge clk);
      mask[b] = err_c[0];
      want = {1'b1, (b == 0), (b == 10), 1'b0};
      got = {out_valid_c, first_c, last_c, fail_c};
      $display("p1 beat %0d err=%b", b, err_c);
      total++;
      if (got !== want) begin bad++; $display("FAIL p1_beat%0d got=%b want=%b", b, got, want); end
    end
    total++;
    if (mask !== 11'h401) begin bad++; $display("FAIL p1_mask got=%b want=%b", mask, 11'h401); end
    @(negedge clk);
    total++;
    if ({in_ready_c, out_valid_c} !== 2'b10) begin
      bad++; $display("FAIL p1_idle got=%b want=10", {in_ready_c, out_valid_c});
    end
  endtask

  task automatic test_p11();
    logic [14:0] got;
    @(negedge clk);
    sigma2 = 12'h1CF; start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    @(negedge clk);
    got = {out_valid_d, first_d, last_d, err_d, fail_d};
    $display("p11 beat 0 err=%b first=%b last=%b", err_d, first_d, last_d);
    total++;
    if (got !== {3'b111, 11'h401, 1'b0}) begin
      bad++; $display("FAIL p11_beat got=%b want=%b", got, {3'b111, 11'h401, 1'b0});
    end
    @(negedge clk);
    total++;
    if ({in_ready_d, out_valid_d} !== 2'b10) begin
      bad++; $display("FAIL p11_idle got=%b want=10", {in_ready_d, out_valid_d});
    end
  endtask

  initial begin
    test_reset();
    test_single_root(0, "basic");
    test_backpressure();
    test_two_roots();
    test_no_errors();
    test_reset_mid();
    test_p1();
    test_p11();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
